// File: rtl/common_pkg.sv
// Shared word types and constants used across the pipeline.
package common;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u32 NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types shared between the fetch stage and its neighbours.
package pipes;

    import common::*;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD,
        DROP
    } fetch_state_t;

    // Used for both the F/D register and the fetch skid buffer.
    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
        logic exc;
    } fetch_out_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one bus request per instruction, registered F/D output
// with a one-entry skid buffer, and the stall that paces the PC register.
module fetch_stage
    import common::*;
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic [63:0] pc_nxt,
    input  logic        flush,
    input  logic        d_stall,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        pc_stall,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_exc
);

    fetch_state_t state, state_nxt;
    u64           req_addr, req_addr_nxt;
    fetch_out_t   fd, skid, resp_entry, load_data;
    logic         misaligned, resp, accept, load, skid_capture;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt    = state;
        req_addr_nxt = req_addr;
        ireq_valid   = 1'b0;
        pc_stall     = 1'b1;
        load         = 1'b0;
        skid_capture = 1'b0;

        // A misaligned address never reaches the bus; it completes at once as a NOP.
        misaligned = (req_addr[1:0] != 2'b00);
        resp       = iresp_data_ok | misaligned;
        accept     = ~fd.valid | ~d_stall;

        resp_entry.valid = 1'b1;
        resp_entry.pc    = req_addr;
        resp_entry.instr = misaligned ? NOP_INSTR : iresp_data;
        resp_entry.exc   = misaligned;
        load_data        = resp_entry;

        case (state)
            IDLE: begin
                state_nxt    = BUSY;
                req_addr_nxt = flush ? pc_nxt : pc;
            end
            BUSY: begin
                ireq_valid = ~misaligned;
                if (flush) begin
                    if (resp) req_addr_nxt = pc_nxt;
                    else      state_nxt    = DROP;
                end else if (resp) begin
                    if (accept) begin
                        load         = 1'b1;
                        req_addr_nxt = pc_nxt;
                        pc_stall     = 1'b0;
                    end else begin
                        skid_capture = 1'b1;
                        state_nxt    = HOLD;
                    end
                end
            end
            HOLD: begin
                load_data = skid;
                if (flush || accept) begin
                    load         = ~flush;
                    req_addr_nxt = pc_nxt;
                    pc_stall     = 1'b0;
                    state_nxt    = BUSY;
                end
            end
            DROP: begin
                // The abandoned request stays on the bus until it completes.
                ireq_valid = 1'b1;
                if (iresp_data_ok) begin
                    req_addr_nxt = flush ? pc_nxt : pc;
                    state_nxt    = BUSY;
                end
            end
        endcase

        // The PC register must always take the redirect target.
        if (flush) pc_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the values from before this edge.
        if (reset) begin
            state    <= IDLE;
            req_addr <= '0;
            fd       <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nxt;
            req_addr <= req_addr_nxt;
            if (skid_capture) skid <= resp_entry;

            if (flush)                 fd.valid <= 1'b0;
            else if (fd.valid && d_stall) fd    <= fd;
            else if (load)             fd       <= load_data;
            else                       fd.valid <= 1'b0;
        end
    end

    assign ireq_addr = req_addr;
    assign f_valid   = fd.valid;
    assign f_pc      = fd.pc;
    assign f_instr   = fd.instr;
    assign f_exc     = fd.exc;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly downstream of the PC register. Takes the current `pc` and the `pc_nxt` selected for the PC register, and issues one instruction-bus request per instruction. It presents fetched instructions to decode through a registered F/D output, with a one-entry skid buffer. It also drives the PC register's stall so the PC advances only when an instruction has been consumed or a redirect occurs.

## Interface
- Parameters: none. Word widths come from the shared packages.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `pc` in 64: current PC register value.
- `pc_nxt` in 64: value the PC register loads when not stalled; on `flush` it is the redirect target.
- `flush` in 1: redirect from a later stage; kills all in-flight and held fetches.
- `d_stall` in 1: decode cannot accept a new F/D entry this cycle.
- `ireq_valid` out 1: instruction-bus request.
- `ireq_addr` out 64: request address.
- `iresp_data_ok` in 1: response valid; may assert in the same cycle as the request.
- `iresp_data` in 32: instruction word.
- `pc_stall` out 1: stall for the PC register.
- `f_valid` out 1: F/D entry valid.
- `f_pc` out 64: PC of the F/D entry.
- `f_instr` out 32: instruction of the F/D entry.
- `f_exc` out 1: instruction-address-misaligned flag for the F/D entry.

## Operation
- Internal registers:
  - `req_addr` (64): address being fetched.
  - Skid buffer `sk_*`: pc, instr, exc.
  - `state`: one of IDLE, BUSY, HOLD, DROP.
- `accept` = `~f_valid | ~d_stall`.
- IDLE:
  - Entered on reset only.
  - `ireq_valid`=0, `pc_stall`=1.
  - Next cycle: `req_addr`<=`pc`, go to BUSY.
- BUSY:
  - `ireq_valid`=1 and `ireq_addr`=`req_addr`. Exception: if `req_addr[1:0]`≠0, `ireq_valid`=0 and the cycle is treated as an immediate response with instr=NOP (0x00000013) and exc=1.
  - `resp` = `iresp_data_ok` or a misaligned address.
  - `resp & accept & ~flush`: load F/D with (1, `req_addr`, data, exc); `req_addr`<=`pc_nxt`; `pc_stall`=0; stay in BUSY.
  - `resp & ~accept & ~flush`: capture into the skid buffer; `pc_stall`=1; go to HOLD.
  - `~resp & ~flush`: `pc_stall`=1; stay in BUSY.
  - `flush & resp`: discard the data; `req_addr`<=`pc_nxt`; stay in BUSY.
  - `flush & ~resp`: go to DROP. The request stays asserted at the old `req_addr`, as the bus protocol requires.
- HOLD:
  - `ireq_valid`=0.
  - `accept & ~flush`: load F/D from the skid buffer; `req_addr`<=`pc_nxt`; `pc_stall`=0; go to BUSY.
  - Otherwise `pc_stall`=1.
  - `flush`: discard the skid buffer; `req_addr`<=`pc_nxt`; go to BUSY.
- DROP:
  - `ireq_valid`=1 at the old `req_addr`.
  - On `iresp_data_ok`: discard the data; `req_addr`<=`pc`, which already holds the redirect target; go to BUSY.
  - A further `flush` while in DROP stays in DROP.
- `pc_stall` is 0 in every `flush` cycle, so the PC register loads the redirect target.
- F/D register:
  - `flush`: `f_valid`<=0.
  - Else if `f_valid & d_stall`: hold.
  - Else if a load occurs this cycle: load.
  - Else `f_valid`<=0.

## Timing
- Reset values:
  - state=IDLE, `req_addr`=0.
  - `f_valid`=0, `f_pc`=0, `f_instr`=0, `f_exc`=0.
  - `ireq_valid`=0, `pc_stall`=1.
- Latency:
  - First request is issued 1 cycle after reset deasserts.
  - With a zero-wait bus, an instruction appears on `f_*` the cycle after its response.
  - Steady-state throughput is one instruction per cycle.
- `ireq_addr` is stable from the first cycle of a request until `iresp_data_ok`.
- `flush` has priority over `d_stall` and over responses.
- Reset asserted mid-request: `ireq_valid` drops the next cycle; the bus side is reset globally.
- Arithmetic: no adders. PC increment and redirect selection are upstream in `pc_nxt`.

## Structure
- `pipes`: `fetch_state_t` enum (IDLE, BUSY, HOLD, DROP); `fetch_out_t` struct {valid, pc, instr, exc} used for both the F/D register and the skid buffer.
- `common`: `NOP_INSTR` = 32'h00000013; `u64` and `u32` types.
- Single module. The skid buffer is a `fetch_out_t` register inline; no sub-module.

## Test plan
- Reset with `pc`=0x80000000, `pc_nxt`=`pc`+4, zero-wait bus: `ireq_addr` shows 0x80000000 on cycle 1, then 0x80000004; `f_valid`=1 with `f_pc`=0x80000000 on cycle 2; `pc_stall`=0 from cycle 1.
- 3-cycle bus latency: `pc_stall`=1 and `ireq_addr` stable for 2 cycles; `f_*` updates once per 3 cycles.
- `d_stall`=1 when a response arrives: the entry goes to HOLD and `ireq_valid`=0. On release, `f_*` shows the held instruction and the next request goes to `pc_nxt`. No instruction is lost or duplicated.
- `flush` with target 0x80001000 while waiting on 0x80000008: the request stays at 0x80000008 until `data_ok`, the data is dropped, the next request goes to 0x80001000, and `f_valid`=0 in between.
- `flush` in the same cycle as `data_ok`: the data is discarded and the next cycle requests the redirect target.
- Redirect to 0x80000002: `ireq_valid`=0; the F/D entry has `f_exc`=1, `f_instr`=0x00000013, `f_pc`=0x80000002.
